// File: rtl/uart_tx_sched.sv
// Round-robin scheduler that funnels bytes from N_REQ producers into the UART TX register.
// Polls STAT until tx_full clears, then writes TX; failed writes are retried, then dropped.
module uart_tx_sched #(
    parameter int          N_REQ     = 2,
    parameter logic [31:0] UART_BASE = 32'h0000_0000,
    parameter int          POLL_GAP  = 4,
    parameter int          MAX_RETRY = 3
) (
    input  logic               g_clk,
    input  logic               g_reset,
    output logic               g_clk_req,
    input  logic [N_REQ-1:0]   req_valid,
    input  logic [8*N_REQ-1:0] req_data,
    output logic [N_REQ-1:0]   req_ready,
    output logic [N_REQ-1:0]   drop_err,
    input  logic               drop_clr,
    output logic               mem_req,
    input  logic               mem_gnt,
    output logic               mem_wen,
    output logic [31:0]        mem_addr,
    output logic [31:0]        mem_wdata,
    output logic [3:0]         mem_strb,
    input  logic [31:0]        mem_rdata,
    input  logic               mem_error
);
    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_ACK, S_POLL, S_POLL_RSP, S_WAIT, S_PREP, S_WRITE, S_WRITE_RSP
    } state_t;

    state_t           state_q, state_d;
    logic [PW-1:0]    rr_ptr_q, rr_ptr_d;
    logic [PW-1:0]    sel_q, sel_d;
    logic [7:0]       byte_q, byte_d;
    logic [RW-1:0]    retry_q, retry_d;
    logic [7:0]       gap_q, gap_d;
    logic [N_REQ-1:0] ready_q, ready_d;
    logic [N_REQ-1:0] drop_q, drop_d;

    logic             found;
    logic [PW-1:0]    pick;
    logic [PW-1:0]    next_ptr;

    // Only tx_full is meaningful in STAT.
    logic unused_rdata;
    assign unused_rdata = ^{mem_rdata[31:4], mem_rdata[2:0]};

    // Scan from the highest offset down so the nearest valid index at/after rr_ptr wins.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (req_valid[(int'(rr_ptr_q) + k) % N_REQ]) begin
                found = 1'b1;
                pick  = PW'((int'(rr_ptr_q) + k) % N_REQ);
            end
        end
    end

    assign next_ptr  = (int'(sel_q) == N_REQ - 1) ? '0 : sel_q + PW'(1);
    assign g_clk_req = (|req_valid) || (state_q != S_IDLE);
    assign req_ready = ready_q;
    assign drop_err  = drop_q;

    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        sel_d     = sel_q;
        byte_d    = byte_q;
        retry_d   = retry_q;
        gap_d     = gap_q;
        ready_d   = '0;
        drop_d    = drop_q;
        mem_req   = 1'b0;
        mem_wen   = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_strb  = '0;

        if (drop_clr) drop_d = '0;

        case (state_q)
            S_IDLE: begin
                if (found) begin
                    ready_d[pick] = 1'b1;
                    sel_d         = pick;
                    byte_d        = req_data[8*pick +: 8];
                    retry_d       = '0;
                    state_d       = S_ACK;
                end
            end
            S_ACK: state_d = S_POLL;
            S_POLL: begin
                mem_req  = 1'b1;
                mem_addr = UART_BASE + 32'd8;
                if (mem_gnt) state_d = S_POLL_RSP;
            end
            S_POLL_RSP: begin
                if (mem_error || mem_rdata[3]) begin
                    if (POLL_GAP == 0) begin
                        state_d = S_POLL;
                    end else begin
                        gap_d   = 8'(POLL_GAP);
                        state_d = S_WAIT;
                    end
                end else begin
                    state_d = S_PREP;
                end
            end
            S_WAIT: begin
                gap_d = gap_q - 8'd1;
                if (gap_q == 8'd1) state_d = S_POLL;
            end
            // Turnaround cycle between the STAT response and driving the TX write.
            S_PREP: state_d = S_WRITE;
            S_WRITE: begin
                mem_req   = 1'b1;
                mem_wen   = 1'b1;
                mem_addr  = UART_BASE + 32'd4;
                mem_wdata = {24'b0, byte_q};
                mem_strb  = 4'b0001;
                if (mem_gnt) state_d = S_WRITE_RSP;
            end
            S_WRITE_RSP: begin
                if (!mem_error) begin
                    rr_ptr_d = next_ptr;
                    state_d  = S_IDLE;
                end else if (retry_q < RW'(MAX_RETRY)) begin
                    retry_d = retry_q + RW'(1);
                    state_d = S_POLL;
                end else begin
                    // Applied after the clear so a same-cycle set wins.
                    drop_d[sel_q] = 1'b1;
                    rr_ptr_d      = next_ptr;
                    state_d       = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge g_clk) begin
        if (g_reset) begin
            state_q  <= S_IDLE;
            rr_ptr_q <= '0;
            sel_q    <= '0;
            byte_q   <= '0;
            retry_q  <= '0;
            gap_q    <= '0;
            ready_q  <= '0;
            drop_q   <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            sel_q    <= sel_d;
            byte_q   <= byte_d;
            retry_q  <= retry_d;
            gap_q    <= gap_d;
            ready_q  <= ready_d;
            drop_q   <= drop_d;
        end
    end
endmodule

// File: tb/tb_uart_tx_sched.sv
// Bench for uart_tx_sched: a bus slave and two byte producers driven each negedge,
// with expected write order derived from a queue-level round-robin model.
module tb_uart_tx_sched;
    localparam int N  = 2;
    localparam int PG = 4;
    localparam int MR = 3;

    logic          g_clk = 1'b0;
    logic          g_reset;
    logic          g_clk_req;
    logic [N-1:0]  req_valid;
    logic [8*N-1:0] req_data;
    logic [N-1:0]  req_ready;
    logic [N-1:0]  drop_err;
    logic          drop_clr;
    logic          mem_req;
    logic          mem_gnt;
    logic          mem_wen;
    logic [31:0]   mem_addr;
    logic [31:0]   mem_wdata;
    logic [3:0]    mem_strb;
    logic [31:0]   mem_rdata;
    logic          mem_error;

    always #5 g_clk = ~g_clk;

    uart_tx_sched #(.N_REQ(N), .UART_BASE(32'h0), .POLL_GAP(PG), .MAX_RETRY(MR)) dut (
        .g_clk(g_clk), .g_reset(g_reset), .g_clk_req(g_clk_req),
        .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
        .drop_err(drop_err), .drop_clr(drop_clr),
        .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_wen(mem_wen), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_strb(mem_strb), .mem_rdata(mem_rdata), .mem_error(mem_error)
    );

    typedef struct {
        int          cyc;
        logic        wen;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
    } txn_t;

    txn_t       txq[$];
    int         rdyc[$];
    int         rdys[$];
    logic [7:0] rq0[$];
    logic [7:0] rq1[$];

    int total = 0, bad = 0, cyc = 0;
    int stab_bad = 0, ready_bad = 0, stall_wr_cycles = 0;
    int busy_left = 0, busy_pct = 0, rderr_pct = 0, gnt_pct = 100, wr_stall_left = 0;
    logic wr_err_all = 1'b0;
    logic hs_prev = 1'b0, hs_wen_prev = 1'b0, prev_stall = 1'b0, prev_wen = 1'b0;
    logic [31:0] prev_addr = '0, prev_wdata = '0;
    logic [3:0]  prev_strb = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int n_of(input logic w);
        int n = 0;
        foreach (txq[i]) if (txq[i].wen == w) n++;
        return n;
    endfunction

    function automatic txn_t nth(input logic w, input int k);
        txn_t r;
        int   n = 0;
        r = '{-1, 1'b0, 32'h0, 32'h0, 4'h0};
        foreach (txq[i]) begin
            if (txq[i].wen == w) begin
                if (n == k) r = txq[i];
                n++;
            end
        end
        return r;
    endfunction

    function automatic int rdy_c(input int k);
        return (k < rdyc.size()) ? rdyc[k] : -1;
    endfunction

    function automatic int rdy_s(input int k);
        return (k < rdys.size()) ? rdys[k] : -1;
    endfunction

    // One cycle: answer last cycle's handshake, pick this cycle's grant, observe, drive producers.
    task automatic step();
        logic         gnt_now;
        logic [N-1:0] rdy;
        logic [7:0]   tmp;
        @(negedge g_clk);
        cyc++;
        mem_rdata = $urandom;
        mem_error = 1'($urandom_range(1));
        if (hs_prev) begin
            if (hs_wen_prev) begin
                mem_error = wr_err_all;
            end else begin
                mem_rdata = $urandom & 32'hFFFF_FFF7;
                if (busy_left > 0) begin
                    busy_left--;
                    mem_rdata[3] = 1'b1;
                end else if ($urandom_range(99) < busy_pct) begin
                    mem_rdata[3] = 1'b1;
                end
                mem_error = ($urandom_range(99) < rderr_pct);
            end
        end
        if (mem_req && mem_wen && wr_stall_left > 0) begin
            gnt_now = 1'b0;
            wr_stall_left--;
        end else begin
            gnt_now = ($urandom_range(99) < gnt_pct);
        end
        mem_gnt = gnt_now;

        rdy = req_ready;
        if (rdy != '0) begin
            if (!$onehot(rdy)) ready_bad++;
            for (int i = 0; i < N; i++) begin
                if (rdy[i]) begin
                    rdyc.push_back(cyc);
                    rdys.push_back(i);
                    if (i == 0 && rq0.size() > 0) tmp = rq0.pop_front();
                    if (i == 1 && rq1.size() > 0) tmp = rq1.pop_front();
                end
            end
        end
        if (prev_stall && (mem_req !== 1'b1 || mem_wen !== prev_wen || mem_addr !== prev_addr ||
                           mem_wdata !== prev_wdata || mem_strb !== prev_strb))
            stab_bad++;
        if (mem_req && mem_wen && !gnt_now) stall_wr_cycles++;
        prev_stall  = mem_req && !gnt_now;
        prev_wen    = mem_wen;
        prev_addr   = mem_addr;
        prev_wdata  = mem_wdata;
        prev_strb   = mem_strb;
        hs_prev     = mem_req && gnt_now;
        hs_wen_prev = mem_wen;
        if (hs_prev) txq.push_back('{cyc, mem_wen, mem_addr, mem_wdata, mem_strb});

        req_valid[0]  = (rq0.size() > 0);
        req_valid[1]  = (rq1.size() > 0);
        req_data[7:0]  = (rq0.size() > 0) ? rq0[0] : 8'($urandom);
        req_data[15:8] = (rq1.size() > 0) ? rq1[0] : 8'($urandom);
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic clear_logs();
        txq.delete();
        rdyc.delete();
        rdys.delete();
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_ready"}, 32'(req_ready), 0);
        chk({tag, "_drop"}, 32'(drop_err), 0);
        chk({tag, "_req"}, 32'(mem_req), 0);
        chk({tag, "_wen"}, 32'(mem_wen), 0);
        chk({tag, "_addr"}, mem_addr, 0);
        chk({tag, "_wdata"}, mem_wdata, 0);
        chk({tag, "_strb"}, 32'(mem_strb), 0);
        chk({tag, "_clkreq"}, 32'(g_clk_req), 0);
    endtask

    initial begin
        int          t_valid, budget, mptr, nbad, n_exp, s;
        logic [7:0]  qa[$], qb[$], exp_b[$];
        int          exp_s[$];
        txn_t        t, u;

        g_reset = 1'b1; drop_clr = 1'b0; mem_gnt = 1'b0;
        mem_rdata = '0; mem_error = 1'b0; req_valid = '0; req_data = '0;

        // Reset state
        run(3);
        chk_quiet("rst");
        g_reset = 1'b0;
        run(2);

        // Single byte, uncontended
        clear_logs();
        rq0.push_back(8'h41);
        step();
        t_valid = cyc;
        run(40);
        t = nth(1'b0, 0);
        u = nth(1'b1, 0);
        chk("s1_rdy_cnt", rdyc.size(), 1);
        chk("s1_rdy_idx", rdy_s(0), 0);
        chk("s1_rdy_lat", rdy_c(0), t_valid + 1);
        chk("s1_n_rd", n_of(1'b0), 1);
        chk("s1_n_wr", n_of(1'b1), 1);
        chk("s1_rd_addr", t.addr, 32'h8);
        chk("s1_rd_strb", 32'(t.strb), 0);
        chk("s1_poll_lat", t.cyc, rdy_c(0) + 1);
        chk("s1_wr_addr", u.addr, 32'h4);
        chk("s1_wr_data", u.wdata, 32'h41);
        chk("s1_wr_strb", 32'(u.strb), 1);
        chk("s1_wr_lat", u.cyc, t.cyc + 3);
        chk("s1_drop", 32'(drop_err), 0);

        // Busy polling: STAT full for three polls
        clear_logs();
        busy_left = 3;
        rq1.push_back(8'h3C);
        run(80);
        chk("s2_n_rd", n_of(1'b0), 4);
        chk("s2_n_wr", n_of(1'b1), 1);
        for (int k = 1; k < 4; k++)
            chk("s2_poll_gap", nth(1'b0, k).cyc - nth(1'b0, k - 1).cyc, PG + 2);
        chk("s2_wr_lat", nth(1'b1, 0).cyc, nth(1'b0, 3).cyc + 3);
        chk("s2_wr_data", nth(1'b1, 0).wdata, 32'h3C);
        chk("s2_rdy_idx", rdy_s(0), 1);

        // Round-robin with both producers always valid
        clear_logs();
        rq0.push_back(8'hAA); rq0.push_back(8'hAA);
        rq1.push_back(8'h55); rq1.push_back(8'h55);
        run(80);
        chk("s3_n_wr", n_of(1'b1), 4);
        for (int k = 0; k < 4; k++) begin
            chk("s3_wr_data", nth(1'b1, k).wdata, (k % 2 == 0) ? 32'hAA : 32'h55);
            chk("s3_rdy_idx", rdy_s(k), k % 2);
        end
        chk("s3_ready_onehot", ready_bad, 0);

        // Grant stall during the TX write
        clear_logs();
        stall_wr_cycles = 0;
        stab_bad = 0;
        wr_stall_left = 5;
        rq0.push_back(8'hC3);
        run(60);
        chk("s4_stall_cycles", stall_wr_cycles, 5);
        chk("s4_stable", stab_bad, 0);
        chk("s4_n_wr", n_of(1'b1), 1);
        chk("s4_wr_data", nth(1'b1, 0).wdata, 32'hC3);

        // Every TX write errors: retries exhausted, byte dropped
        clear_logs();
        wr_err_all = 1'b1;
        rq1.push_back(8'hE7);
        run(100);
        chk("s5_n_wr", n_of(1'b1), MR + 1);
        chk("s5_n_rd", n_of(1'b0), MR + 1);
        chk("s5_wr_data", nth(1'b1, MR).wdata, 32'hE7);
        chk("s5_drop", 32'(drop_err), 32'b10);
        chk("s5_idle", 32'(mem_req), 0);
        wr_err_all = 1'b0;
        drop_clr = 1'b1;
        step();
        drop_clr = 1'b0;
        step();
        chk("s5_drop_clr", 32'(drop_err), 0);

        // Randomized rounds against the queue-level round-robin model
        mptr = 0;
        for (int r = 0; r < 6; r++) begin
            clear_logs();
            gnt_pct = $urandom_range(50, 100);
            busy_pct = $urandom_range(0, 40);
            rderr_pct = $urandom_range(0, 15);
            n_exp = $urandom_range(1, 4);
            for (int k = 0; k < n_exp; k++) rq0.push_back(8'($urandom));
            n_exp = $urandom_range(0, 4);
            for (int k = 0; k < n_exp; k++) rq1.push_back(8'($urandom));
            qa = rq0; qb = rq1;
            exp_b.delete(); exp_s.delete();
            while (qa.size() + qb.size() > 0) begin
                s = mptr;
                if ((s == 0 && qa.size() == 0) || (s == 1 && qb.size() == 0)) s = 1 - s;
                if (s == 0) exp_b.push_back(qa.pop_front());
                else        exp_b.push_back(qb.pop_front());
                exp_s.push_back(s);
                mptr = (s + 1) % N;
            end
            budget = 0;
            while (n_of(1'b1) < exp_b.size() && budget < 3000) begin
                step();
                budget++;
            end
            chk("rand_done", 32'(budget < 3000), 1);
            run(4);
            chk("rand_n_wr", n_of(1'b1), exp_b.size());
            for (int k = 0; k < exp_b.size(); k++) begin
                chk("rand_wr_data", nth(1'b1, k).wdata, {24'b0, exp_b[k]});
                chk("rand_rdy_idx", rdy_s(k), exp_s[k]);
            end
            nbad = 0;
            foreach (txq[i]) begin
                if (!txq[i].wen && (txq[i].addr != 32'h8 || txq[i].strb != 4'h0)) nbad++;
                if (txq[i].wen && (txq[i].addr != 32'h4 || txq[i].strb != 4'h1)) nbad++;
            end
            chk("rand_bus_fields", nbad, 0);
        end
        chk("rand_stable", stab_bad, 0);
        chk("rand_ready_onehot", ready_bad, 0);
        gnt_pct = 100; busy_pct = 0; rderr_pct = 0;

        // Reset mid-operation while waiting between polls
        clear_logs();
        rq0.push_back(8'h11);
        run(40);
        chk("s7_pre_wr", nth(1'b1, 0).wdata, 32'h11);
        clear_logs();
        busy_left = 1000;
        rq0.push_back(8'h99);
        budget = 0;
        while (n_of(1'b0) == 0 && budget < 50) begin
            step();
            budget++;
        end
        chk("s7_poll_seen", 32'(budget < 50), 1);
        step();
        step();
        chk("s7_wait_no_req", 32'(mem_req), 0);
        g_reset = 1'b1;
        step();
        chk_quiet("s7_rst");
        g_reset = 1'b0;
        busy_left = 0;
        step();
        clear_logs();
        rq0.push_back(8'h5A);
        rq1.push_back(8'hA5);
        run(80);
        chk("s7_n_wr", n_of(1'b1), 2);
        chk("s7_wr0", nth(1'b1, 0).wdata, 32'h5A);
        chk("s7_wr1", nth(1'b1, 1).wdata, 32'hA5);
        chk("s7_rdy0", rdy_s(0), 0);
        chk("s7_rdy1", rdy_s(1), 1);
        chk("s7_drop", 32'(drop_err), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
